cmd_bus_master: RTL and testbench
=================================

CMD_BUS_MASTER -- requirements
Module: cmd_bus_master

Interface
REQ-001 Parameter DW, default 32: bus data width; command/response word width is DW+2.
REQ-002 Parameter AW, default 30: bus word-address width; AW SHALL be at most DW-2 (elaboration error otherwise).
REQ-003 Parameter TIMEOUT, default 15: bus cycles waited for ack/err before abort; range 1..255.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 cmd_stb  in  1  host command strobe, one-cycle qualifier for cmd_word.
REQ-007 cmd_word  in  DW+2  [DW+1:DW] opcode, [DW-1:0] payload.
REQ-008 cmd_busy  out  1  high while a command is in progress.
REQ-009 rsp_stb  out  1  one-cycle response strobe.
REQ-010 rsp_word  out  DW+2  [DW+1:DW] response code, [DW-1:0] payload.
REQ-011 bus_req  out  1  bus request, held until ack, err or timeout.
REQ-012 bus_we  out  1  1 = write, 0 = read; stable while bus_req is high.
REQ-013 bus_addr  out  AW  word address; stable while bus_req is high.
REQ-014 bus_wdata  out  DW  write data; stable while bus_req is high.
REQ-015 bus_ack  in  1  single-cycle completion from the slave.
REQ-016 bus_err  in  1  single-cycle error from the slave.
REQ-017 bus_rdata  in  DW  read data, valid with bus_ack.

Function
REQ-018 Command acceptance: cmd_stb && !cmd_busy; cmd_stb while busy SHALL be ignored, never queued.
REQ-019 Opcodes:
- 2'b10 SET_ADDR: bit DW-1 relative (1 = add sign-extended payload[AW-1:0] to the current address, 0 = load it); bit DW-2 hold (1 = no post-increment).
- 2'b01 WRITE: write payload to the current address.
- 2'b00 READ: read from the current address.
- 2'b11 reserved.
REQ-020 States: IDLE, BUS, RESP.
- IDLE->BUS on an accepted READ or WRITE.
- IDLE->RESP on an accepted SET_ADDR or reserved opcode.
- BUS->RESP on bus_ack, bus_err or timeout.
- RESP->IDLE unconditionally.
REQ-021 cmd_busy SHALL be high in BUS and RESP, and from the cycle after acceptance; low in IDLE.
REQ-022 Bus timing: bus_req rises the cycle after acceptance; it falls the cycle after ack/err/timeout; rsp_stb is asserted in that same cycle.
REQ-023 Response codes:
- 2'b00 read data (payload = bus_rdata captured at ack).
- 2'b01 write ack (payload = 0).
- 2'b10 address ack (payload = zero-extended new address).
- 2'b11 error (payload = faulting address, or 0 for a reserved opcode).
REQ-024 Post-increment: after a successful access with hold = 0, the address SHALL increment by 1 modulo 2^AW (2^AW-1 wraps to 0); there is no increment on error or timeout.
REQ-025 Relative SET_ADDR arithmetic SHALL be modulo 2^AW.
REQ-026 Timeout: an 8-bit counter clears on entry to BUS and increments each BUS cycle without ack/err; when it reaches TIMEOUT, the block SHALL drop bus_req and respond with code 2'b11.
REQ-027 Priority in the same cycle: bus_err over bus_ack; bus_ack over timeout.
REQ-028 bus_ack/bus_err outside BUS SHALL be ignored.
REQ-029 rsp_word SHALL hold its last value between strobes.

Reset
REQ-030 Reset values: state IDLE, address 0, hold 0, counter 0, all outputs 0.
REQ-031 Reset during BUS SHALL drop bus_req in the next cycle with no rsp_stb; a pending ack after reset SHALL be ignored.

Structure
REQ-032 Package cmd_bus_pkg SHALL hold the opcode constants, response-code constants and the state enumeration.
REQ-033 The timeout counter SHALL be the sub-module cmd_bus_timeout (parameter TIMEOUT; ports clk, reset, clear, enable, expired); there are no other sub-modules.

Verification (DW=32, AW=30, TIMEOUT=15)
REQ-034 SET_ADDR {10,0,1,30'h0C} -> rsp_stb 1 cycle later, rsp_word {10,32'h0000000C}; no bus_req.
REQ-035 WRITE {01,32'hAABBCCDD} at address 0x0C, hold=0, slave ack after 3 cycles -> bus_addr 0x0C, bus_wdata AABBCCDD, rsp {01,0}; then READ with rdata 0x12345678 -> bus_addr 0x0D, rsp {00,12345678}.
REQ-036 READ at address 0x3FFFFFFF, hold=0, ack -> next READ bus_addr 0x0.
REQ-037 READ with no slave response -> bus_req high exactly 15 cycles, rsp {11,0000000C}, address unchanged.
REQ-038 bus_ack and bus_err in the same cycle -> rsp code 11; reserved opcode -> rsp {11,0}.
REQ-039 reset asserted during BUS, then ack -> no rsp_stb, outputs 0, state IDLE; cmd_stb while busy -> no effect.

Source files
------------

// File: rtl/cmd_bus_pkg.sv
// Shared constants and state encoding for the command-driven bus master.
package cmd_bus_pkg;

    localparam int unsigned OP_W = 2;

    localparam logic [OP_W-1:0] OP_READ     = 2'b00;
    localparam logic [OP_W-1:0] OP_WRITE    = 2'b01;
    localparam logic [OP_W-1:0] OP_SET_ADDR = 2'b10;
    localparam logic [OP_W-1:0] OP_RSVD     = 2'b11;

    localparam logic [OP_W-1:0] RSP_READ  = 2'b00;
    localparam logic [OP_W-1:0] RSP_WRITE = 2'b01;
    localparam logic [OP_W-1:0] RSP_ADDR  = 2'b10;
    localparam logic [OP_W-1:0] RSP_ERR   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/cmd_bus_timeout.sv
// Bus-cycle watchdog: counts stalled bus cycles and flags the cycle the limit is hit.
module cmd_bus_timeout #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = 8;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_inc;

    assign count_inc = count_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= count_inc;
        end
    end

    // Combinational so the master can leave BUS on the very edge the count reaches the limit.
    assign expired = enable && !clear && (count_inc == CNT_W'(TIMEOUT));

endmodule

// File: rtl/cmd_bus_master.sv
// Host-command to single-word bus master with auto-incrementing address and timeout.
module cmd_bus_master
    import cmd_bus_pkg::*;
#(
    parameter int unsigned DW      = 32,
    parameter int unsigned AW      = 30,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cmd_stb,
    input  logic [DW+1:0]   cmd_word,
    output logic            cmd_busy,
    output logic            rsp_stb,
    output logic [DW+1:0]   rsp_word,
    output logic            bus_req,
    output logic            bus_we,
    output logic [AW-1:0]   bus_addr,
    output logic [DW-1:0]   bus_wdata,
    input  logic            bus_ack,
    input  logic            bus_err,
    input  logic [DW-1:0]   bus_rdata
);

    if (AW > DW - 2) begin : g_aw_check
        $error("cmd_bus_master: AW must be at most DW-2");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_check
        $error("cmd_bus_master: TIMEOUT must be within 1..255");
    end

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            hold_q, hold_d;
    logic            busy_q, busy_d;
    logic            rsp_stb_q, rsp_stb_d;
    logic [DW+1:0]   rsp_word_q, rsp_word_d;
    logic            bus_req_q, bus_req_d;
    logic            bus_we_q, bus_we_d;
    logic [DW-1:0]   bus_wdata_q, bus_wdata_d;

    logic [OP_W-1:0] opcode_c;
    logic [DW-1:0]   payload_c;
    logic [AW-1:0]   set_addr_c;
    logic            tmo_clear_c;
    logic            tmo_enable_c;
    logic            tmo_expired_c;

    assign opcode_c  = cmd_word[DW+1:DW];
    assign payload_c = cmd_word[DW-1:0];

    // Relative offsets are AW-bit two's complement, so plain AW-bit addition sign-extends and wraps.
    assign set_addr_c = payload_c[DW-1] ? (addr_q + payload_c[AW-1:0]) : payload_c[AW-1:0];

    assign tmo_enable_c = (state_q == ST_BUS) && !bus_ack && !bus_err;

    cmd_bus_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (tmo_clear_c),
        .enable  (tmo_enable_c),
        .expired (tmo_expired_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            hold_q      <= 1'b0;
            busy_q      <= 1'b0;
            rsp_stb_q   <= 1'b0;
            rsp_word_q  <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            hold_q      <= hold_d;
            busy_q      <= busy_d;
            rsp_stb_q   <= rsp_stb_d;
            rsp_word_q  <= rsp_word_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_wdata_q <= bus_wdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        hold_d      = hold_q;
        rsp_stb_d   = 1'b0;
        rsp_word_d  = rsp_word_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_wdata_d = bus_wdata_q;
        tmo_clear_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_stb && !busy_q) begin
                    case (opcode_c)
                        OP_READ, OP_WRITE: begin
                            state_d     = ST_BUS;
                            bus_req_d   = 1'b1;
                            bus_we_d    = (opcode_c == OP_WRITE);
                            tmo_clear_c = 1'b1;
                            if (opcode_c == OP_WRITE) begin
                                bus_wdata_d = payload_c;
                            end
                        end
                        OP_SET_ADDR: begin
                            state_d    = ST_RESP;
                            addr_d     = set_addr_c;
                            hold_d     = payload_c[DW-2];
                            rsp_stb_d  = 1'b1;
                            rsp_word_d = {RSP_ADDR, DW'(set_addr_c)};
                        end
                        default: begin
                            state_d    = ST_RESP;
                            rsp_stb_d  = 1'b1;
                            rsp_word_d = {RSP_ERR, {DW{1'b0}}};
                        end
                    endcase
                end
            end

            // Error beats ack, ack beats timeout; only a successful access advances the address.
            ST_BUS: begin
                if (bus_err || (!bus_ack && tmo_expired_c)) begin
                    state_d    = ST_RESP;
                    bus_req_d  = 1'b0;
                    rsp_stb_d  = 1'b1;
                    rsp_word_d = {RSP_ERR, DW'(addr_q)};
                end else if (bus_ack) begin
                    state_d    = ST_RESP;
                    bus_req_d  = 1'b0;
                    rsp_stb_d  = 1'b1;
                    rsp_word_d = bus_we_q ? {RSP_WRITE, {DW{1'b0}}} : {RSP_READ, bus_rdata};
                    if (!hold_q) begin
                        addr_d = addr_q + AW'(1);
                    end
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d   = ST_IDLE;
                bus_req_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign cmd_busy  = busy_q;
    assign rsp_stb   = rsp_stb_q;
    assign rsp_word  = rsp_word_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_cmd_bus_master.sv
// Directed bench for cmd_bus_master: response scoreboard plus bus-side checks.
module tb_cmd_bus_master;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 30;

    logic            clk = 1'b0;
    logic            reset;
    logic            cmd_stb;
    logic [DW+1:0]   cmd_word;
    logic            cmd_busy;
    logic            rsp_stb;
    logic [DW+1:0]   rsp_word;
    logic            bus_req;
    logic            bus_we;
    logic [AW-1:0]   bus_addr;
    logic [DW-1:0]   bus_wdata;
    logic            bus_ack;
    logic            bus_err;
    logic [DW-1:0]   bus_rdata;

    int checks = 0;
    int errors = 0;

    logic [DW+1:0] sb_word[$];
    string         sb_tag[$];

    cmd_bus_master #(
        .DW      (DW),
        .AW      (AW),
        .TIMEOUT (15)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_stb   (cmd_stb),
        .cmd_word  (cmd_word),
        .cmd_busy  (cmd_busy),
        .rsp_stb   (rsp_stb),
        .rsp_word  (rsp_word),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_err   (bus_err),
        .bus_rdata (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Response monitor: every rsp_stb must match the oldest expected response.
    always @(negedge clk) begin
        if (rsp_stb === 1'b1) begin
            if (sb_word.size() == 0) begin
                check("rsp_unexpected", 64'(rsp_stb), 64'd0);
            end else begin
                logic [DW+1:0] exp_w;
                string         tag;
                exp_w = sb_word.pop_front();
                tag   = sb_tag.pop_front();
                check(tag, 64'(rsp_word), 64'(exp_w));
            end
        end
    end

    task automatic expect_rsp(input string tag, input logic [1:0] code, input logic [DW-1:0] data);
        sb_word.push_back({code, data});
        sb_tag.push_back(tag);
    endtask

    // Drive one command for one cycle; returns on the negedge after acceptance.
    task automatic issue(input logic [1:0] op, input logic [DW-1:0] payload);
        @(negedge clk);
        cmd_stb  = 1'b1;
        cmd_word = {op, payload};
        @(negedge clk);
        cmd_stb  = 1'b0;
        cmd_word = '0;
    endtask

    // Slave completion after 'wait_cycles' extra BUS cycles, then back to IDLE.
    task automatic slave_reply(input int wait_cycles, input logic ack, input logic err,
                               input logic [DW-1:0] rdata, input string tag);
        repeat (wait_cycles) @(negedge clk);
        bus_ack   = ack;
        bus_err   = err;
        bus_rdata = rdata;
        @(negedge clk);
        bus_ack   = 1'b0;
        bus_err   = 1'b0;
        bus_rdata = '0;
        check({tag, "_req_drop"}, 64'(bus_req), 64'd0);
        @(negedge clk);
        check({tag, "_idle"}, 64'(cmd_busy), 64'd0);
    endtask

    initial begin
        int cnt;
        reset     = 1'b1;
        cmd_stb   = 1'b0;
        cmd_word  = '0;
        bus_ack   = 1'b0;
        bus_err   = 1'b0;
        bus_rdata = '0;
        repeat (3) @(negedge clk);
        check("rst_busy",  64'(cmd_busy),  64'd0);
        check("rst_req",   64'(bus_req),   64'd0);
        check("rst_rsp",   64'(rsp_word),  64'd0);
        check("rst_addr",  64'(bus_addr),  64'd0);
        check("rst_wdata", 64'(bus_wdata), 64'd0);
        reset = 1'b0;

        // Load 0x0C with hold set: immediate address ack, no bus activity.
        expect_rsp("set_c_hold", 2'b10, 32'h0000_000C);
        issue(2'b10, {1'b0, 1'b1, 30'h0C});
        check("set_no_req", 64'(bus_req), 64'd0);
        check("set_busy",   64'(cmd_busy), 64'd1);
        @(negedge clk);

        expect_rsp("set_c", 2'b10, 32'h0000_000C);
        issue(2'b10, {1'b0, 1'b0, 30'h0C});
        @(negedge clk);

        // Write with ack in the third bus cycle; a command during BUS is dropped.
        expect_rsp("wr_ack", 2'b01, 32'h0);
        issue(2'b01, 32'hAABB_CCDD);
        check("wr_req",   64'(bus_req),   64'd1);
        check("wr_we",    64'(bus_we),    64'd1);
        check("wr_addr",  64'(bus_addr),  64'h0C);
        check("wr_wdata", 64'(bus_wdata), 64'hAABB_CCDD);
        cmd_stb  = 1'b1;
        cmd_word = {2'b10, 32'h0000_0055};
        @(negedge clk);
        cmd_stb  = 1'b0;
        cmd_word = '0;
        check("wr_req_held", 64'(bus_req), 64'd1);
        slave_reply(1, 1'b1, 1'b0, '0, "wr");

        expect_rsp("rd_data", 2'b00, 32'h1234_5678);
        issue(2'b00, 32'h0);
        check("rd_addr", 64'(bus_addr), 64'h0D);
        check("rd_we",   64'(bus_we),   64'd0);
        slave_reply(0, 1'b1, 1'b0, 32'h1234_5678, "rd");

        // Post-increment wraps from the top address to 0.
        expect_rsp("set_top", 2'b10, 32'h3FFF_FFFF);
        issue(2'b10, {1'b0, 1'b0, 30'h3FFF_FFFF});
        @(negedge clk);
        expect_rsp("rd_top", 2'b00, 32'hCAFE_F00D);
        issue(2'b00, 32'h0);
        check("rd_top_addr", 64'(bus_addr), 64'h3FFF_FFFF);
        slave_reply(0, 1'b1, 1'b0, 32'hCAFE_F00D, "rd_top");
        expect_rsp("rd_wrap", 2'b00, 32'h1111_0000);
        issue(2'b00, 32'h0);
        check("rd_wrap_addr", 64'(bus_addr), 64'h0);
        slave_reply(0, 1'b1, 1'b0, 32'h1111_0000, "rd_wrap");

        // Timeout: bus_req held exactly 15 cycles, error with address, no increment.
        expect_rsp("set_c2", 2'b10, 32'h0000_000C);
        issue(2'b10, {1'b0, 1'b0, 30'h0C});
        @(negedge clk);
        expect_rsp("tmo_rsp", 2'b11, 32'h0000_000C);
        issue(2'b00, 32'h0);
        cnt = 0;
        for (int i = 0; i < 40 && bus_req; i++) begin
            cnt++;
            @(negedge clk);
        end
        check("tmo_req_cycles", 64'(cnt), 64'd15);
        @(negedge clk);
        check("tmo_idle", 64'(cmd_busy), 64'd0);
        expect_rsp("rd_after_tmo", 2'b00, 32'hA5A5_A5A5);
        issue(2'b00, 32'h0);
        check("tmo_addr_kept", 64'(bus_addr), 64'h0C);
        slave_reply(0, 1'b1, 1'b0, 32'hA5A5_A5A5, "rd_after_tmo");

        // Ack and err together: error wins, address stays at 0x0D.
        expect_rsp("ackerr_rsp", 2'b11, 32'h0000_000D);
        issue(2'b00, 32'h0);
        slave_reply(0, 1'b1, 1'b1, 32'hDEAD_0000, "ackerr");
        expect_rsp("wr_after_err", 2'b01, 32'h0);
        issue(2'b01, 32'h0102_0304);
        check("err_addr_kept", 64'(bus_addr), 64'h0D);
        slave_reply(0, 1'b1, 1'b0, '0, "wr_after_err");

        // Relative SET_ADDR by -2 from 0x0E lands on 0x0C.
        expect_rsp("set_rel", 2'b10, 32'h0000_000C);
        issue(2'b10, {1'b1, 1'b0, 30'h3FFF_FFFE});
        @(negedge clk);

        expect_rsp("rsvd", 2'b11, 32'h0);
        issue(2'b11, 32'hFFFF_FFFF);
        @(negedge clk);

        // Stray ack in IDLE must not produce a response.
        bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        @(negedge clk);
        check("stray_ack_idle", 64'(cmd_busy), 64'd0);

        expect_rsp("rd_rel", 2'b00, 32'h600D_F00D);
        issue(2'b00, 32'h0);
        check("rd_rel_addr", 64'(bus_addr), 64'h0C);
        slave_reply(0, 1'b1, 1'b0, 32'h600D_F00D, "rd_rel");

        // Reset in BUS: req drops next cycle, no response, late ack ignored.
        issue(2'b01, 32'h5555_AAAA);
        check("rstbus_req", 64'(bus_req), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset   = 1'b0;
        bus_ack = 1'b1;
        check("rstbus_req_drop", 64'(bus_req), 64'd0);
        check("rstbus_busy",     64'(cmd_busy), 64'd0);
        @(negedge clk);
        bus_ack = 1'b0;
        check("rstbus_no_rsp", 64'(rsp_stb),   64'd0);
        check("rstbus_rsp",    64'(rsp_word),  64'd0);
        check("rstbus_addr",   64'(bus_addr),  64'd0);
        check("rstbus_wdata",  64'(bus_wdata), 64'd0);
        check("rstbus_we",     64'(bus_we),    64'd0);
        @(negedge clk);

        expect_rsp("rd_post_rst", 2'b00, 32'h0BAD_BEEF);
        issue(2'b00, 32'h0);
        check("rd_post_rst_addr", 64'(bus_addr), 64'h0);
        slave_reply(0, 1'b1, 1'b0, 32'h0BAD_BEEF, "rd_post_rst");

        repeat (2) @(negedge clk);
        check("sb_drained", 64'(sb_word.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
